// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: shared types and default 1280x1024 timing for the VGA receiver.
`default_nettype none

package vga_rx_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } rx_state_e;

    typedef enum logic [11:0] {
        COL_BLACK = 12'h000,
        COL_RED   = 12'hF00,
        COL_GREEN = 12'h0F0,
        COL_BLUE  = 12'h00F,
        COL_WHITE = 12'hFFF
    } colour_e;

    localparam int DEF_HD          = 1280;
    localparam int DEF_HF          = 48;
    localparam int DEF_HR          = 112;
    localparam int DEF_HB          = 248;
    localparam int DEF_VD          = 1024;
    localparam int DEF_VF          = 1;
    localparam int DEF_VR          = 3;
    localparam int DEF_VB          = 38;
    localparam int DEF_LOCK_FRAMES = 2;

endpackage

`default_nettype wire

// File: rtl/vga_rx_if.sv
// vga_rx_if: incoming VGA timing/colour plus the recovered pixel stream and status.
`default_nettype none

interface vga_rx_if #(
    parameter int HSYNC_BITS = 11,
    parameter int VSYNC_BITS = 11
);
    logic                  hs_i;
    logic                  vs_i;
    logic [11:0]           rgb_i;
    logic                  pix_valid_o;
    logic [HSYNC_BITS-1:0] pix_x_o;
    logic [VSYNC_BITS-1:0] pix_y_o;
    logic [11:0]           pix_rgb_o;
    logic                  frame_start_o;
    logic                  locked_o;
    logic                  err_o;
    logic [7:0]            err_cnt_o;
    logic [HSYNC_BITS-1:0] h_total_o;
    logic [VSYNC_BITS-1:0] v_total_o;

    modport slave (
        input  hs_i, vs_i, rgb_i,
        output pix_valid_o, pix_x_o, pix_y_o, pix_rgb_o, frame_start_o,
        output locked_o, err_o, err_cnt_o, h_total_o, v_total_o
    );

    modport master (
        output hs_i, vs_i, rgb_i,
        input  pix_valid_o, pix_x_o, pix_y_o, pix_rgb_o, frame_start_o,
        input  locked_o, err_o, err_cnt_o, h_total_o, v_total_o
    );
endinterface

`default_nettype wire

// File: rtl/vga_rx_axis.sv
// vga_rx_axis: saturating position counter with restart strobe, length capture and
// raw (ungated) timing-error flag for one axis.
`default_nettype none

module vga_rx_axis #(
    parameter int BITS = 11,
    parameter int MAX  = 1687
) (
    input  wire logic            clk,
    input  wire logic            arstn,
    input  wire logic            step,
    input  wire logic            restart,
    output logic      [BITS-1:0] pos,
    output logic      [BITS-1:0] len,
    output logic                 err
);
    localparam logic [BITS-1:0] LAST = BITS'(MAX);
    localparam logic [BITS-1:0] OVER = BITS'(MAX + 1);
    localparam logic [BITS-1:0] SAT  = '1;

    logic [BITS-1:0] q;

    always_comb begin
        pos = q;
        if (restart) begin
            pos = '0;
        end else if (step && (q != SAT)) begin
            pos = q + 1'b1;
        end
    end

    // Overrun is flagged only on the step that lands on MAX+1, so it fires once.
    assign err = (restart && (q != LAST)) ||
                 (step && !restart && (pos == OVER) && (q != OVER));

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            q   <= '0;
            len <= '0;
        end else begin
            q <= pos;
            if (restart) begin
                len <= q + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_rx.sv
// vga_rx: recovers pixel position from hsync/vsync, checks line/frame lengths,
// locks after LOCK_FRAMES clean frames and emits a registered pixel stream.
`default_nettype none

module vga_rx
    import vga_rx_pkg::*;
#(
    parameter int HSYNC_BITS  = 11,
    parameter int VSYNC_BITS  = 11,
    parameter int HD          = DEF_HD,
    parameter int HF          = DEF_HF,
    parameter int HR          = DEF_HR,
    parameter int HB          = DEF_HB,
    parameter int VD          = DEF_VD,
    parameter int VF          = DEF_VF,
    parameter int VR          = DEF_VR,
    parameter int VB          = DEF_VB,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input wire logic clk,
    input wire logic arstn,
    vga_rx_if.slave  bus
);
    localparam int HMAX = HD + HF + HR + HB - 1;
    localparam int VMAX = VD + VF + VR + VB - 1;

    localparam logic [HSYNC_BITS-1:0] X_START = HSYNC_BITS'(HR + HB);
    localparam logic [HSYNC_BITS-1:0] X_END   = HSYNC_BITS'(HR + HB + HD);
    localparam logic [VSYNC_BITS-1:0] Y_START = VSYNC_BITS'(VR + VB);
    localparam logic [VSYNC_BITS-1:0] Y_END   = VSYNC_BITS'(VR + VB + VD);
    localparam logic [7:0]            GOOD_TARGET = 8'(LOCK_FRAMES);

    logic                  hs_d;
    logic                  vs_at_rise;
    logic                  hs_rise;
    logic                  frame_start;
    logic [HSYNC_BITS-1:0] h_pos;
    logic [HSYNC_BITS-1:0] h_len;
    logic                  h_err;
    logic [VSYNC_BITS-1:0] v_pos;
    logic [VSYNC_BITS-1:0] v_len;
    logic                  v_err;
    logic                  err_any;

    rx_state_e             state;
    rx_state_e             state_next;
    logic [7:0]            good;
    logic [7:0]            good_next;

    logic                  locked_n;
    logic                  disp;
    logic                  valid_n;
    logic                  fs_n;
    logic [HSYNC_BITS-1:0] x_n;
    logic [VSYNC_BITS-1:0] y_n;

    assign hs_rise     = bus.hs_i & ~hs_d;
    // vs level is compared against its value at the previous hs rise, not the previous clk.
    assign frame_start = hs_rise & bus.vs_i & ~vs_at_rise;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            hs_d       <= 1'b0;
            vs_at_rise <= 1'b0;
        end else begin
            hs_d <= bus.hs_i;
            if (hs_rise) begin
                vs_at_rise <= bus.vs_i;
            end
        end
    end

    vga_rx_axis #(.BITS(HSYNC_BITS), .MAX(HMAX)) u_h_axis (
        .clk     (clk),
        .arstn   (arstn),
        .step    (1'b1),
        .restart (hs_rise),
        .pos     (h_pos),
        .len     (h_len),
        .err     (h_err)
    );

    vga_rx_axis #(.BITS(VSYNC_BITS), .MAX(VMAX)) u_v_axis (
        .clk     (clk),
        .arstn   (arstn),
        .step    (hs_rise),
        .restart (frame_start),
        .pos     (v_pos),
        .len     (v_len),
        .err     (v_err)
    );

    assign err_any = (state != ST_SEARCH) && (h_err || v_err);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state <= ST_SEARCH;
            good  <= '0;
        end else begin
            state <= state_next;
            good  <= good_next;
        end
    end

    always_comb begin
        state_next = state;
        good_next  = good;
        case (state)
            ST_SEARCH: begin
                if (frame_start) begin
                    state_next = ST_ACQUIRE;
                    good_next  = '0;
                end
            end
            ST_ACQUIRE: begin
                if (err_any) begin
                    state_next = ST_SEARCH;
                end else if (frame_start) begin
                    good_next = good + 8'd1;
                    if (good_next == GOOD_TARGET) begin
                        state_next = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (err_any) begin
                    state_next = ST_SEARCH;
                end
            end
            default: state_next = ST_SEARCH;
        endcase
    end

    // Outputs are derived from the next state so lock/unlock lands on the same edge as the state.
    always_comb begin
        locked_n = (state_next == ST_LOCKED);
        disp     = (h_pos >= X_START) && (h_pos < X_END) &&
                   (v_pos >= Y_START) && (v_pos < Y_END);
        valid_n  = locked_n && disp;
        fs_n     = locked_n && frame_start;
        x_n      = disp ? (h_pos - X_START) : '0;
        y_n      = disp ? (v_pos - Y_START) : '0;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            bus.pix_valid_o   <= 1'b0;
            bus.pix_x_o       <= '0;
            bus.pix_y_o       <= '0;
            bus.pix_rgb_o     <= '0;
            bus.frame_start_o <= 1'b0;
            bus.locked_o      <= 1'b0;
            bus.err_o         <= 1'b0;
            bus.err_cnt_o     <= '0;
        end else begin
            bus.pix_valid_o   <= valid_n;
            bus.pix_x_o       <= x_n;
            bus.pix_y_o       <= y_n;
            bus.pix_rgb_o     <= bus.rgb_i;
            bus.frame_start_o <= fs_n;
            bus.locked_o      <= locked_n;
            bus.err_o         <= err_any;
            if (err_any && (bus.err_cnt_o != 8'hFF)) begin
                bus.err_cnt_o <= bus.err_cnt_o + 8'd1;
            end
        end
    end

    assign bus.h_total_o = h_len;
    assign bus.v_total_o = v_len;

endmodule

`default_nettype wire

// File: tb/tb_vga_rx.sv
// tb_vga_rx: directed VGA source with a pixel scoreboard and status checks.
`default_nettype none

module tb_vga_rx;
    localparam int HLEN = 15;
    localparam int VLEN = 8;
    localparam int HR   = 2;
    localparam int HB   = 3;
    localparam int HD   = 8;
    localparam int VR   = 1;
    localparam int VB   = 2;
    localparam int VD   = 4;

    logic clk   = 1'b0;
    logic arstn = 1'b1;

    vga_rx_if #(.HSYNC_BITS(11), .VSYNC_BITS(11)) bus ();

    vga_rx #(
        .HSYNC_BITS(11), .VSYNC_BITS(11),
        .HD(8), .HF(2), .HR(2), .HB(3),
        .VD(4), .VF(1), .VR(1), .VB(2),
        .LOCK_FRAMES(2)
    ) dut (
        .clk   (clk),
        .arstn (arstn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int err_pulses  = 0;
    logic [33:0] exp_q[$];

    logic        s_err, s_locked, s_fs, s_pv;
    logic [7:0]  s_cnt;
    logic [10:0] s_ht, s_vt, s_x, s_y;
    logic [11:0] s_rgb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] rgb_of(input int h, input int v);
        logic [3:0] hh;
        logic [3:0] vv;
        hh = 4'(h);
        vv = 4'(v);
        if (h == 5 && v == 3) return 12'hABC;
        return {hh, vv, 4'h5};
    endfunction

    task automatic snap();
        s_err    = bus.err_o;
        s_locked = bus.locked_o;
        s_fs     = bus.frame_start_o;
        s_pv     = bus.pix_valid_o;
        s_cnt    = bus.err_cnt_o;
        s_ht     = bus.h_total_o;
        s_vt     = bus.v_total_o;
        s_x      = bus.pix_x_o;
        s_y      = bus.pix_y_o;
        s_rgb    = bus.pix_rgb_o;
    endtask

    // One source line, beats h0..len-1; sync occupies the first HR beats.
    task automatic drive_line(input int h0, input int len, input int v, input bit push, input int snap_h);
        for (int h = h0; h < len; h++) begin
            bus.hs_i  = (h < HR);
            bus.vs_i  = (v < VR);
            bus.rgb_i = rgb_of(h, v);
            if (push && h >= HR + HB && h < HR + HB + HD && v >= VR + VB && v < VR + VB + VD)
                exp_q.push_back({11'(h - HR - HB), 11'(v - VR - VB), rgb_of(h, v)});
            @(posedge clk);
            #1;
            if (h == snap_h) snap();
        end
    endtask

    task automatic drive_frame(input int nlines, input bit push);
        for (int v = 0; v < nlines; v++)
            drive_line(0, HLEN, v, push, (v == 0) ? 0 : -1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.hs_i  = 1'b0;
            bus.vs_i  = 1'b0;
            bus.rgb_i = 12'h000;
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        logic [33:0] e;
        if (bus.err_o) err_pulses++;
        if (bus.pix_valid_o) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pix_unexpected: got x=%0d y=%0d rgb=%0h expected no beat",
                         bus.pix_x_o, bus.pix_y_o, bus.pix_rgb_o);
            end else begin
                e = exp_q.pop_front();
                if ({bus.pix_x_o, bus.pix_y_o, bus.pix_rgb_o} !== e) begin
                    miscompares++;
                    $display("FAIL pix_beat: got x=%0d y=%0d rgb=%0h expected x=%0d y=%0d rgb=%0h",
                             bus.pix_x_o, bus.pix_y_o, bus.pix_rgb_o, e[33:23], e[22:12], e[11:0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.hs_i = 1'b0;
        bus.vs_i = 1'b0;
        bus.rgb_i = 12'h000;
        #1 arstn = 1'b0;
        #2;
        snap();
        chk("reset_flags", {s_err, s_locked, s_fs, s_pv}, 0);
        chk("reset_counts", {s_cnt, s_ht, s_vt}, 0);
        chk("reset_pixel", {s_x, s_y, s_rgb}, 0);
        idle(3);
        arstn = 1'b1;

        // clean lock-up
        drive_frame(VLEN, 0);
        chk("f1_locked", s_locked, 0);
        drive_frame(VLEN, 0);
        chk("f2_locked", s_locked, 0);
        chk("f2_fs", s_fs, 0);
        drive_frame(VLEN, 1);
        chk("f3_locked", s_locked, 1);
        for (int v = 0; v < 3; v++) drive_line(0, HLEN, v, 1, (v == 0) ? 0 : -1);
        chk("f4_fs", s_fs, 1);
        chk("f4_h_total", s_ht, 15);
        chk("f4_v_total", s_vt, 8);
        chk("f4_err_pulses", err_pulses, 0);
        drive_line(0, 6, 3, 1, 5);
        chk("first_pix_valid", s_pv, 1);
        chk("first_pix_xy", {s_x, s_y}, 0);
        chk("first_pix_rgb", s_rgb, 12'hABC);
        chk("first_pix_fs", s_fs, 0);
        drive_line(6, 14, 3, 1, 13);
        chk("h13_valid", s_pv, 0);
        drive_line(14, HLEN, 3, 1, -1);
        for (int v = 4; v < VLEN; v++) drive_line(0, HLEN, v, 1, -1);

        // early hs rise
        drive_line(0, HLEN, 0, 1, -1);
        drive_line(0, 13, 1, 0, -1);
        drive_line(0, HLEN, 2, 0, 0);
        chk("early_err", s_err, 1);
        chk("early_locked", s_locked, 0);
        chk("early_cnt", s_cnt, 1);
        chk("early_h_total", s_ht, 13);
        for (int v = 3; v < VLEN; v++) drive_line(0, HLEN, v, 0, -1);
        drive_frame(VLEN, 0);
        chk("relock1_locked", s_locked, 0);
        drive_frame(VLEN, 0);
        chk("relock2_locked", s_locked, 0);
        drive_frame(VLEN, 1);
        chk("relock3_locked", s_locked, 1);
        chk("early_pulses", err_pulses, 1);

        // hs held low past HMAX
        drive_line(0, HLEN, 0, 1, -1);
        drive_line(0, 20, 1, 0, 15);
        chk("long_err", s_err, 1);
        chk("long_locked", s_locked, 0);
        chk("long_cnt", s_cnt, 2);
        for (int v = 2; v < VLEN; v++) drive_line(0, HLEN, v, 0, -1);
        drive_frame(VLEN, 0);
        drive_frame(VLEN, 0);
        drive_frame(VLEN, 1);
        chk("long_relock", s_locked, 1);
        chk("long_pulses", err_pulses, 2);

        // short frame while locked, then while searching
        drive_frame(7, 1);
        drive_frame(7, 0);
        chk("vshort_err", s_err, 1);
        chk("vshort_locked", s_locked, 0);
        chk("vshort_v_total", s_vt, 7);
        chk("vshort_cnt", s_cnt, 3);
        drive_frame(VLEN, 0);
        chk("vsearch_err", s_err, 0);
        chk("vsearch_v_total", s_vt, 7);
        chk("vsearch_cnt", s_cnt, 3);
        drive_frame(VLEN, 0);
        drive_frame(VLEN, 1);
        chk("vshort_relock", s_locked, 1);
        chk("vshort_pulses", err_pulses, 3);

        // asynchronous reset mid-line
        for (int v = 0; v < 4; v++) drive_line(0, HLEN, v, 1, -1);
        drive_line(0, 7, 4, 1, -1);
        #5;
        chk("pre_reset_valid", bus.pix_valid_o, 1);
        arstn = 1'b0;
        #1;
        snap();
        chk("midrst_flags", {s_err, s_locked, s_fs, s_pv}, 0);
        chk("midrst_counts", {s_cnt, s_ht, s_vt}, 0);
        chk("midrst_pixel", {s_x, s_y, s_rgb}, 0);
        idle(3);
        arstn = 1'b1;
        idle(5);
        for (int v = 5; v < VLEN; v++) drive_line(0, HLEN, v, 0, -1);
        drive_frame(VLEN, 0);
        chk("rst_relock1", s_locked, 0);
        chk("rst_cnt", s_cnt, 0);
        drive_frame(VLEN, 0);
        chk("rst_relock2", s_locked, 0);
        drive_frame(VLEN, 1);
        chk("rst_relock3", s_locked, 1);

        // 300 short lines, each preceded by a frame start that re-arms checking
        for (int i = 0; i < 300; i++) begin
            drive_line(0, 5, 0, 0, -1);
            drive_line(0, 5, 1, 0, -1);
        end
        snap();
        chk("sat_cnt", s_cnt, 255);
        chk("sat_locked", s_locked, 0);
        chk("sat_pulses", err_pulses, 303);
        idle(2);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
